cpu_regfile_scoreboard: RTL and testbench
=========================================

CPU_REGFILE_SCOREBOARD -- requirements
Module: cpu_regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, index width; N_REGS = 2**ADDR_W registers, derived, not overridable.
REQ-003 SHALL have parameter ZERO_REG, default 0; 1 makes index 0 hardwired to zero.
REQ-004 SHALL have port clk_i, input, 1, sole clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port we_i, input, 1, write enable.
REQ-007 SHALL have port waddr_i, input, ADDR_W, write index.
REQ-008 SHALL have port wdata_i, input, DATA_W, write data.
REQ-009 SHALL have port re_i, input, 1, read enable for both read ports.
REQ-010 SHALL have ports raddr1_i and raddr2_i, input, ADDR_W each, read indices.
REQ-011 SHALL have ports rdata1_o and rdata2_o, output, DATA_W each, registered read data.
REQ-012 SHALL have port rvalid_o, output, 1, read data valid pulse.
REQ-013 SHALL have ports rbusy1_o and rbusy2_o, output, 1 each, registered pending-write flags for the read indices.
REQ-014 SHALL have port rsv_i, input, 1, reserve request that marks a register pending.
REQ-015 SHALL have port rsv_addr_i, input, ADDR_W, reserve index.
REQ-016 SHALL have port err_o, output, 1, double-reservation error pulse.

Function
REQ-017 SHALL write wdata_i to reg[waddr_i] at the edge where we_i=1, for every index 0..N_REGS-1 with no gaps.
REQ-018 SHALL, at an edge with re_i=1, load rdataX_o with reg[raddrX_i] and set rvalid_o=1 for exactly one cycle, giving 1-cycle read latency.
REQ-019 SHALL, at an edge with re_i=0, hold rdataX_o and rbusyX_o and drive rvalid_o=0.
REQ-020 SHALL bypass writes: same edge we_i=1, re_i=1, waddr_i==raddrX_i loads rdataX_o with wdata_i; this applies to each port independently and to both ports at once.
REQ-021 SHALL keep one busy bit per register; rsv_i=1 sets busy[rsv_addr_i]; we_i=1 clears busy[waddr_i].
REQ-022 SHALL resolve rsv_i and we_i on the same index at the same edge as set wins: data is written and busy ends at 1.
REQ-023 SHALL load rbusyX_o on a read edge with the next-state busy bit of raddrX_i, i.e. the value after the same-edge set/clear of REQ-021/022.
REQ-024 SHALL pulse err_o=1 for one cycle on rsv_i=1 targeting an index already busy and not cleared that same edge; busy stays 1 and no other state changes.
REQ-025 SHALL, when ZERO_REG=1: ignore writes to index 0 and never set busy[0], read index 0 as 0 with rbusy 0 and no bypass, and never assert err_o for index 0.
REQ-026 SHALL keep reads free of side effects on register or busy state.

Reset
REQ-027 SHALL, at an edge with rst_i=1, clear all registers, all busy bits, rdata1_o, rdata2_o, rbusy1_o, rbusy2_o, rvalid_o and err_o to 0.
REQ-028 SHALL give rst_i priority over we_i, re_i and rsv_i at the same edge; those requests are discarded, not deferred.
REQ-029 SHALL accept operations at the first edge after rst_i falls; reset asserted mid-sequence SHALL abort pending reservations.

Verification
REQ-030 SHALL cover: reset, then write 0xDEADBEEF to idx 6, then read raddr1=6 -> rdata1_o=0xDEADBEEF, rvalid_o=1 one cycle later for one cycle.
REQ-031 SHALL cover: same edge we=1 waddr=3 wdata=0x12345678, re=1 raddr1=3 raddr2=3 -> both rdata=0x12345678 next cycle.
REQ-032 SHALL cover: rsv idx 5, read 5 -> rbusy1_o=1; write idx 5 -> busy cleared, reread -> rbusy1_o=0; rsv 5 twice -> err_o=1 on the second.
REQ-033 SHALL cover: same edge rsv=1 and we=1 on idx 9 -> reg[9]=wdata, busy[9]=1, err_o=0.
REQ-034 SHALL cover: ZERO_REG=1, write 0xFFFFFFFF to idx 0, read 0 -> rdata=0, rbusy=0.
REQ-035 SHALL cover: rst_i=1 with we=1 idx 2 at the same edge -> reg[2]=0 and all outputs 0 afterwards.

Source files
------------

// File: rtl/cpu_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_regfile_scoreboard
//  Purpose  : Two-read / one-write register file with one registered read
//             port pair, write-to-read bypass and a per-register busy
//             (pending-write) scoreboard with double-reservation detection.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o,
    output logic              rvalid_o,
    output logic              rbusy1_o,
    output logic              rbusy2_o,
    input  logic              rsv_i,
    input  logic [ADDR_W-1:0] rsv_addr_i,
    output logic              err_o
);

    localparam int   N_REGS    = 2 ** ADDR_W;
    localparam logic c_zero_en = (ZERO_REG != 0);

    logic [DATA_W-1:0] r_regs [N_REGS];
    logic [N_REGS-1:0] r_busy;

    logic [N_REGS-1:0] w_busy_nxt;
    logic              w_wr_en;
    logic              w_rsv_en;
    logic              w_err;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    // Index 0 is inert when hardwired: writes and reservations to it vanish.
    assign w_wr_en  = we_i  && !(c_zero_en && (waddr_i    == '0));
    assign w_rsv_en = rsv_i && !(c_zero_en && (rsv_addr_i == '0));

    // A reservation on a busy register is an error unless the same edge's
    // write retires the pending value (then the new reservation simply wins).
    assign w_err = w_rsv_en && r_busy[rsv_addr_i]
                   && !(w_wr_en && (waddr_i == rsv_addr_i));

    // Next-state busy vector: write clears first, reservation sets last.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_en) begin
            w_busy_nxt[waddr_i] = 1'b0;
        end
        if (w_rsv_en) begin
            w_busy_nxt[rsv_addr_i] = 1'b1;
        end
    end

    // Read muxes with same-edge write bypass; hardwired zero overrides all.
    always_comb begin
        w_rd1 = r_regs[raddr1_i];
        w_rd2 = r_regs[raddr2_i];
        if (w_wr_en && (waddr_i == raddr1_i)) begin
            w_rd1 = wdata_i;
        end
        if (w_wr_en && (waddr_i == raddr2_i)) begin
            w_rd2 = wdata_i;
        end
        if (c_zero_en && (raddr1_i == '0)) begin
            w_rd1 = '0;
        end
        if (c_zero_en && (raddr2_i == '0)) begin
            w_rd2 = '0;
        end
    end

    // Register storage and busy scoreboard state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr_en) begin
                r_regs[waddr_i] <= wdata_i;
            end
            r_busy <= w_busy_nxt;
        end
    end

    // Registered read results, valid strobe and error pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata1_o <= '0;
            rdata2_o <= '0;
            rbusy1_o <= 1'b0;
            rbusy2_o <= 1'b0;
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= re_i;
            err_o    <= w_err;
            if (re_i) begin
                rdata1_o <= w_rd1;
                rdata2_o <= w_rd2;
                rbusy1_o <= w_busy_nxt[raddr1_i];
                rbusy2_o <= w_busy_nxt[raddr2_i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_regfile_scoreboard
//  Purpose  : Self-checking bench: vector table feeding an expected-result
//             queue, plus hand-written hardwired-zero sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_regfile_scoreboard;

    typedef struct {
        logic        rst;
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [3:0]  r1;
        logic [3:0]  r2;
        logic        rsv;
        logic [3:0]  ra;
        logic        ev;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eb1;
        logic        eb2;
        logic        eer;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, we, re, rsv;
    logic [3:0]  waddr, raddr1, raddr2, rsv_addr;
    logic [31:0] wdata;

    logic [31:0] rd1_a, rd2_a, rd1_z, rd2_z;
    logic        rv_a, rb1_a, rb2_a, er_a;
    logic        rv_z, rb1_z, rb2_z, er_z;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t tbl [24];
    vec_t exp_q [$];

    always #5 clk = ~clk;

    cpu_regfile_scoreboard #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(0)) dut (
        .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .re_i(re), .raddr1_i(raddr1), .raddr2_i(raddr2),
        .rdata1_o(rd1_a), .rdata2_o(rd2_a), .rvalid_o(rv_a),
        .rbusy1_o(rb1_a), .rbusy2_o(rb2_a),
        .rsv_i(rsv), .rsv_addr_i(rsv_addr), .err_o(er_a)
    );

    cpu_regfile_scoreboard #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1)) dut_z (
        .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .re_i(re), .raddr1_i(raddr1), .raddr2_i(raddr2),
        .rdata1_o(rd1_z), .rdata2_o(rd2_z), .rvalid_o(rv_z),
        .rbusy1_o(rb1_z), .rbusy2_o(rb2_z),
        .rsv_i(rsv), .rsv_addr_i(rsv_addr), .err_o(er_z)
    );

    function automatic vec_t v(
        input logic rst_v, input logic we_v, input logic [3:0] wa_v,
        input logic [31:0] wd_v, input logic re_v, input logic [3:0] r1_v,
        input logic [3:0] r2_v, input logic rsv_v, input logic [3:0] ra_v,
        input logic ev_v, input logic [31:0] e1_v, input logic [31:0] e2_v,
        input logic eb1_v, input logic eb2_v, input logic eer_v);
        vec_t t;
        t.rst = rst_v; t.we = we_v; t.wa = wa_v; t.wd = wd_v; t.re = re_v;
        t.r1 = r1_v; t.r2 = r2_v; t.rsv = rsv_v; t.ra = ra_v;
        t.ev = ev_v; t.e1 = e1_v; t.e2 = e2_v;
        t.eb1 = eb1_v; t.eb2 = eb2_v; t.eer = eer_v;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; we = t.we; waddr = t.wa; wdata = t.wd; re = t.re;
        raddr1 = t.r1; raddr2 = t.r2; rsv = t.rsv; rsv_addr = t.ra;
    endtask

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input vec_t t);
        @(negedge clk);
        drive(t);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t t, e;
        //         rst we wa     wd            re r1     r2     rsv ra     ev e1            e2            b1 b2 er
        tbl[0]  = v(1, 1, 4'd2,  32'hAAAA5555, 0, 4'd0,  4'd0,  0, 4'd0,  0, 32'h0,        32'h0,        0, 0, 0);
        tbl[1]  = v(0, 0, 4'd0,  32'h0,        1, 4'd2,  4'd6,  0, 4'd0,  1, 32'h0,        32'h0,        0, 0, 0);
        tbl[2]  = v(0, 1, 4'd6,  32'hDEADBEEF, 0, 4'd0,  4'd0,  0, 4'd0,  0, 32'h0,        32'h0,        0, 0, 0);
        tbl[3]  = v(0, 0, 4'd0,  32'h0,        1, 4'd6,  4'd0,  0, 4'd0,  1, 32'hDEADBEEF, 32'h0,        0, 0, 0);
        tbl[4]  = v(0, 0, 4'd0,  32'h0,        0, 4'd0,  4'd0,  0, 4'd0,  0, 32'hDEADBEEF, 32'h0,        0, 0, 0);
        tbl[5]  = v(0, 1, 4'd3,  32'h12345678, 1, 4'd3,  4'd3,  0, 4'd0,  1, 32'h12345678, 32'h12345678, 0, 0, 0);
        tbl[6]  = v(0, 0, 4'd0,  32'h0,        1, 4'd3,  4'd6,  0, 4'd0,  1, 32'h12345678, 32'hDEADBEEF, 0, 0, 0);
        tbl[7]  = v(0, 1, 4'd7,  32'h0BADF00D, 1, 4'd6,  4'd7,  0, 4'd0,  1, 32'hDEADBEEF, 32'h0BADF00D, 0, 0, 0);
        tbl[8]  = v(0, 0, 4'd0,  32'h0,        0, 4'd0,  4'd0,  1, 4'd5,  0, 32'hDEADBEEF, 32'h0BADF00D, 0, 0, 0);
        tbl[9]  = v(0, 0, 4'd0,  32'h0,        1, 4'd5,  4'd3,  0, 4'd0,  1, 32'h0,        32'h12345678, 1, 0, 0);
        tbl[10] = v(0, 0, 4'd0,  32'h0,        0, 4'd0,  4'd0,  1, 4'd5,  0, 32'h0,        32'h12345678, 1, 0, 1);
        tbl[11] = v(0, 0, 4'd0,  32'h0,        0, 4'd0,  4'd0,  0, 4'd0,  0, 32'h0,        32'h12345678, 1, 0, 0);
        tbl[12] = v(0, 1, 4'd5,  32'h55555555, 1, 4'd5,  4'd5,  0, 4'd0,  1, 32'h55555555, 32'h55555555, 0, 0, 0);
        tbl[13] = v(0, 0, 4'd0,  32'h0,        1, 4'd5,  4'd9,  0, 4'd0,  1, 32'h55555555, 32'h0,        0, 0, 0);
        tbl[14] = v(0, 1, 4'd9,  32'h99990000, 1, 4'd9,  4'd9,  1, 4'd9,  1, 32'h99990000, 32'h99990000, 1, 1, 0);
        tbl[15] = v(0, 0, 4'd0,  32'h0,        1, 4'd9,  4'd5,  0, 4'd0,  1, 32'h99990000, 32'h55555555, 1, 0, 0);
        tbl[16] = v(0, 1, 4'd9,  32'h11112222, 0, 4'd0,  4'd0,  1, 4'd9,  0, 32'h99990000, 32'h55555555, 1, 0, 0);
        tbl[17] = v(0, 0, 4'd0,  32'h0,        0, 4'd0,  4'd0,  1, 4'd9,  0, 32'h99990000, 32'h55555555, 1, 0, 1);
        tbl[18] = v(1, 0, 4'd0,  32'h0,        1, 4'd9,  4'd0,  1, 4'd4,  0, 32'h0,        32'h0,        0, 0, 0);
        tbl[19] = v(0, 0, 4'd0,  32'h0,        1, 4'd9,  4'd6,  0, 4'd0,  1, 32'h0,        32'h0,        0, 0, 0);
        tbl[20] = v(0, 0, 4'd0,  32'h0,        0, 4'd0,  4'd0,  1, 4'd9,  0, 32'h0,        32'h0,        0, 0, 0);
        tbl[21] = v(0, 1, 4'd15, 32'hF00000FF, 1, 4'd15, 4'd0,  0, 4'd0,  1, 32'hF00000FF, 32'h0,        0, 0, 0);
        tbl[22] = v(0, 1, 4'd0,  32'hFFFFFFFF, 1, 4'd0,  4'd15, 0, 4'd0,  1, 32'hFFFFFFFF, 32'hF00000FF, 0, 0, 0);
        tbl[23] = v(0, 0, 4'd0,  32'h0,        1, 4'd0,  4'd9,  0, 4'd0,  1, 32'hFFFFFFFF, 32'h0,        0, 1, 0);

        drive(v(1, 0, 4'd0, 32'h0, 0, 4'd0, 4'd0, 0, 4'd0, 0, 32'h0, 32'h0, 0, 0, 0));

        for (int i = 0; i < 24; i++) begin
            exp_q.push_back(tbl[i]);
            step(tbl[i]);
            e = exp_q.pop_front();
            chk($sformatf("row%0d.rdata1", i), rd1_a, e.e1);
            chk($sformatf("row%0d.rdata2", i), rd2_a, e.e2);
            chk($sformatf("row%0d.rvalid", i), 32'(rv_a), 32'(e.ev));
            chk($sformatf("row%0d.rbusy1", i), 32'(rb1_a), 32'(e.eb1));
            chk($sformatf("row%0d.rbusy2", i), 32'(rb2_a), 32'(e.eb2));
            chk($sformatf("row%0d.err", i), 32'(er_a), 32'(e.eer));
        end

        // Hardwired-zero instance: reserving index 0 twice never errors.
        t = v(0, 0, 4'd0, 32'h0, 0, 4'd0, 4'd0, 1, 4'd0, 0, 32'h0, 32'h0, 0, 0, 0);
        step(t);
        chk("z.rsv0_first.err", 32'(er_z), 32'h0);
        chk("n.rsv0_first.err", 32'(er_a), 32'h0);
        step(t);
        chk("z.rsv0_second.err", 32'(er_z), 32'h0);
        chk("n.rsv0_second.err", 32'(er_a), 32'h1);

        // Write all-ones to index 0 while reading it on both ports.
        step(v(0, 1, 4'd0, 32'hFFFFFFFF, 1, 4'd0, 4'd0, 0, 4'd0, 0, 32'h0, 32'h0, 0, 0, 0));
        chk("z.wr0_byp.rdata1", rd1_z, 32'h0);
        chk("z.wr0_byp.rdata2", rd2_z, 32'h0);
        chk("z.wr0_byp.rbusy1", 32'(rb1_z), 32'h0);
        chk("z.wr0_byp.rvalid", 32'(rv_z), 32'h1);
        chk("n.wr0_byp.rdata2", rd2_a, 32'hFFFFFFFF);
        chk("n.wr0_byp.rbusy1", 32'(rb1_a), 32'h0);

        step(v(0, 0, 4'd0, 32'h0, 1, 4'd0, 4'd15, 0, 4'd0, 0, 32'h0, 32'h0, 0, 0, 0));
        chk("z.rd0.rdata1", rd1_z, 32'h0);
        chk("z.rd0.rbusy1", 32'(rb1_z), 32'h0);
        chk("z.rd15.rdata2", rd2_z, 32'hF00000FF);
        chk("n.rd0.rdata1", rd1_a, 32'hFFFFFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
